// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
// Also holds the round-robin pick so the policy sits in one place.
package mem_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_grant_t;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // A tie goes to the port that did not win last time.
  function automatic arb_grant_t rr_pick(input logic i_pend, input logic d_pend,
                                         input arb_grant_t last);
    if (i_pend && d_pend) return (last == GNT_I) ? GNT_D : GNT_I;
    return i_pend ? GNT_I : GNT_D;
  endfunction

endpackage

// File: rtl/arb_port_buffer.sv
// One-deep request buffer for an arbiter port: a pending bit plus the fields
// captured with the request pulse. Further pulses are dropped while pending.
module arb_port_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic [DATA_W-1:0]   set_wdata,
  input  logic [DATA_W/8-1:0] set_wmask,
  input  logic                set_we,
  output logic                pending,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wmask,
  output logic                we
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      wmask   <= '0;
      we      <= 1'b0;
    end else if (set && (!pending || clr)) begin
      // A pulse arriving on the edge the old request retires is kept.
      pending <= 1'b1;
      addr    <= set_addr;
      wdata   <= set_wdata;
      wmask   <= set_wmask;
      we      <= set_we;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, with registered bus outputs and a watchdog on each access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_resp,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                timeout_err,
  output logic                busy
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int MASK_W = DATA_W / 8;

  logic              i_pend, d_pend, i_hwe, d_hwe, i_clr, d_clr;
  logic [ADDR_W-1:0] i_haddr, d_haddr;
  logic [DATA_W-1:0] i_hwdata, d_hwdata;
  logic [MASK_W-1:0] i_hwmask, d_hwmask;

  arb_state_t        state, state_d;
  arb_grant_t        last_grant, grant_d;
  logic [CNT_W-1:0]  cnt;
  logic              start, done, timed_out;

  arb_port_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_buf (
    .clk(clk), .rst(rst), .set(i_req), .clr(i_clr),
    .set_addr(i_addr), .set_wdata('0), .set_wmask('0), .set_we(1'b0),
    .pending(i_pend), .addr(i_haddr), .wdata(i_hwdata), .wmask(i_hwmask), .we(i_hwe)
  );

  // A combined read+write pulse is a store.
  arb_port_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_buf (
    .clk(clk), .rst(rst), .set(d_read | d_write), .clr(d_clr),
    .set_addr(d_addr), .set_wdata(d_wdata), .set_wmask(d_wmask), .set_we(d_write),
    .pending(d_pend), .addr(d_haddr), .wdata(d_hwdata), .wmask(d_hwmask), .we(d_hwe)
  );

  // last_grant names the port owning the current access while in ARB_ACCESS.
  assign i_clr = done && (last_grant == GNT_I);
  assign d_clr = done && (last_grant == GNT_D);
  assign busy  = (state == ARB_ACCESS);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    grant_d   = last_grant;
    start     = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (i_pend || d_pend) begin
          start   = 1'b1;
          grant_d = rr_pick(i_pend, d_pend, last_grant);
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (mem_resp) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th strobe cycle with no answer.
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_D;
    end else begin
      state      <= state_d;
      last_grant <= grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      i_resp      <= 1'b0;
      d_resp      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (start) begin
        cnt <= '0;
        if (grant_d == GNT_I) begin
          mem_read  <= !i_hwe;
          mem_write <= i_hwe;
          mem_addr  <= i_haddr;
          mem_wdata <= i_hwdata;
          mem_wmask <= i_hwmask;
        end else begin
          mem_read  <= !d_hwe;
          mem_write <= d_hwe;
          mem_addr  <= d_haddr;
          mem_wdata <= d_hwdata;
          mem_wmask <= d_hwmask;
        end
      end else if (state == ARB_ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (last_grant == GNT_I) begin
          i_resp  <= 1'b1;
          i_rdata <= timed_out ? DATA_W'(ARB_TIMEOUT_RDATA) : mem_rdata;
        end else begin
          d_resp <= 1'b1;
          if (!d_hwe) d_rdata <= timed_out ? DATA_W'(ARB_TIMEOUT_RDATA) : mem_rdata;
        end
      end
      if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected bus
// accesses and responses; one monitor pops and compares as the DUT emits them.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          len;
  } bus_ent_t;

  typedef struct {
    bit          is_d;
    bit          keep;
    logic [31:0] rdata;
  } resp_ent_t;

  logic        clk, rst;
  logic        i_req, d_read, d_write, mem_resp;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        i_resp, d_resp, mem_read, mem_write, timeout_err, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;  // strobe cycles before mem_resp; 0 means never answer

  bus_ent_t  bus_q[$];
  resp_ent_t resp_q[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: answers after mem_lat strobe cycles with address-derived data.
  initial begin
    int sc;
    sc = 0;
    mem_resp = 1'b0;
    mem_rdata = 32'h5555_5555;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sc = 0;
        mem_resp = 1'b0;
      end else if (mem_resp) begin
        mem_resp = 1'b0;
        mem_rdata = 32'h5555_5555;
        sc = 0;
      end else if (mem_read || mem_write) begin
        sc++;
        if (mem_lat != 0 && sc == mem_lat) begin
          mem_resp = 1'b1;
          mem_rdata = mem_value(mem_addr);
        end
      end else begin
        sc = 0;
      end
    end
  end

  // Monitor / scoreboard.
  bus_ent_t    cur;
  resp_ent_t   r;
  int          len_cnt = 0;
  bit          strobe, strobe_prev = 0, resp_prev = 0;
  logic [31:0] exp_d = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        strobe_prev = 0;
        resp_prev = 0;
        len_cnt = 0;
        exp_d = '0;
        bus_q.delete();
        resp_q.delete();
      end else begin
        strobe = mem_read | mem_write;
        if (strobe && !strobe_prev) begin
          check("access_expected", 64'(bus_q.size() > 0), 64'd1);
          if (bus_q.size() > 0) begin
            cur = bus_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(cur.addr));
            check("mem_write", 64'(mem_write), 64'(cur.we));
            if (cur.we) begin
              check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
              check("mem_wmask", 64'(mem_wmask), 64'(cur.wmask));
            end
          end
          len_cnt = 1;
        end else if (strobe) begin
          len_cnt++;
        end else if (strobe_prev) begin
          check("strobe_len", 64'(len_cnt), 64'(cur.len));
        end
        if (i_resp || d_resp) begin
          check("resp_after_strobe", 64'(strobe_prev && !strobe), 64'd1);
          check("resp_one_port", 64'(i_resp & d_resp), 64'd0);
          check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            check("resp_port", 64'(d_resp), 64'(r.is_d));
            if (r.is_d) begin
              if (!r.keep) exp_d = r.rdata;
              check("d_rdata", 64'(d_rdata), 64'(exp_d));
            end else begin
              check("i_rdata", 64'(i_rdata), 64'(r.rdata));
            end
          end
        end
        if (resp_prev) check("resp_single_pulse", 64'(i_resp | d_resp), 64'd0);
        strobe_prev = strobe;
        resp_prev = i_resp | d_resp;
      end
    end
  end

  task automatic push_bus(input logic [31:0] a, input bit we, input logic [31:0] wd,
                          input logic [3:0] wm, input int len);
    bus_ent_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.wmask = wm; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic push_resp(input bit is_d, input bit keep, input logic [31:0] rd);
    resp_ent_t e;
    e.is_d = is_d; e.keep = keep; e.rdata = rd;
    resp_q.push_back(e);
  endtask

  // One-cycle request pulse; returns just after the edge that samples it.
  task automatic issue(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_read = dr; d_write = dw;
    d_addr = da; d_wdata = wd; d_wmask = wm;
    @(posedge clk);
    #1;
    i_req = 0; d_read = 0; d_write = 0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_q.size() == 0 && resp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    check("drain_in_time", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    i_req = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_resp", 64'({i_resp, d_resp}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);

    // Simultaneous pair out of reset: fetch wins the tie.
    mem_lat = 2;
    push_bus(32'h104, 0, 0, 0, 2);
    push_bus(32'h204, 0, 0, 0, 2);
    push_resp(0, 0, 32'hFEFB_0104);
    push_resp(1, 0, 32'hFDFB_0204);
    issue(1, 32'h104, 1, 0, 32'h204, 0, 0);
    wait_done();

    // Single fetch with cycle-exact strobe start.
    push_bus(32'h100, 0, 0, 0, 2);
    push_resp(0, 0, 32'h0000_0013);
    issue(1, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fetch_cycle1_mem_read", 64'(mem_read), 64'd0);
    check("fetch_cycle1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("fetch_cycle2_mem_read", 64'(mem_read), 64'd1);
    check("fetch_cycle2_busy", 64'(busy), 64'd1);
    wait_done();
    check("fetch_rdata_held", 64'(i_rdata), 64'h13);
    check("fetch_resp_low", 64'(i_resp), 64'd0);

    // Next simultaneous pair after a fetch grant: data wins.
    push_bus(32'h208, 0, 0, 0, 2);
    push_bus(32'h108, 0, 0, 0, 2);
    push_resp(1, 0, 32'hFDF7_0208);
    push_resp(0, 0, 32'hFEF7_0108);
    issue(1, 32'h108, 1, 0, 32'h208, 0, 0);
    wait_done();

    // Store: exact bus values, d_rdata untouched.
    mem_lat = 1;
    push_bus(32'h200, 1, 32'hCAFE_F00D, 4'b0011, 1);
    push_resp(1, 1, 0);
    issue(0, 0, 0, 1, 32'h200, 32'hCAFE_F00D, 4'b0011);
    wait_done();
    check("store_d_rdata_kept", 64'(d_rdata), 64'hFDF7_0208);

    // Read and write pulsed together is a store.
    push_bus(32'h204, 1, 32'h1234_5678, 4'hF, 1);
    push_resp(1, 1, 0);
    issue(0, 0, 1, 1, 32'h204, 32'h1234_5678, 4'hF);
    wait_done();

    // Second fetch while the first is pending is dropped.
    mem_lat = 2;
    push_bus(32'h100, 0, 0, 0, 2);
    push_resp(0, 0, 32'h0000_0013);
    @(posedge clk);
    #1 i_req = 1; i_addr = 32'h100;
    @(posedge clk);
    #1 i_addr = 32'h300;
    @(posedge clk);
    #1 i_req = 0;
    wait_done();

    // Watchdog: no answer, strobe exactly TIMEOUT cycles.
    mem_lat = 0;
    push_bus(32'h400, 0, 0, 0, 4);
    push_resp(1, 0, 32'hDEAD_BEEF);
    issue(0, 0, 1, 0, 32'h400, 0, 0);
    wait_done();
    check("timeout_err_set", 64'(timeout_err), 64'd1);

    mem_lat = 1;
    push_bus(32'h10C, 0, 0, 0, 1);
    push_resp(0, 0, 32'hFEF3_010C);
    issue(1, 32'h10C, 0, 0, 0, 0, 0);
    wait_done();
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-access with both ports pending; data wins (fetch went last).
    mem_lat = 0;
    push_bus(32'h600, 0, 0, 0, 0);
    issue(1, 32'h500, 1, 0, 32'h600, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_strobe", 64'(mem_read), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mem_read", 64'(mem_read), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_timeout_err", 64'(timeout_err), 64'd0);
    check("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("async_rst_d_rdata", 64'(d_rdata), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_idle_strobe", 64'(mem_read | mem_write), 64'd0);
    check("post_reset_idle_busy", 64'(busy), 64'd0);
    check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    check("resp_queue_empty", 64'(resp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-fetch path and the load/store data path of the multi-cycle core. Each side issues one-cycle request pulses; the arbiter buffers them, grants the memory bus with round-robin priority, holds strobes until `mem_resp`, and returns a one-cycle response with held read data. A watchdog counter aborts hung accesses.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles an access may wait for `mem_resp` (≥1)
- Reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `i_req`  in  1  fetch read request pulse
- `i_addr`  in  ADDR_W  fetch address, sampled with `i_req`
- `i_resp`  out  1  fetch done pulse
- `i_rdata`  out  DATA_W  fetch data, held until next `i_resp`
- `d_read`, `d_write`  in  1 each  data request pulses
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wmask`  in  DATA_W/8  store byte enables
- `d_resp`  out  1  data done pulse
- `d_rdata`  out  DATA_W  load data, held until next `d_resp`
- `mem_read`, `mem_write`  out  1 each  memory strobes (level)
- `mem_addr`, `mem_wdata`, `mem_wmask`  out  ADDR_W / DATA_W / DATA_W/8  memory bus
- `mem_resp`  in  1  memory done
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_resp`
- `timeout_err`  out  1  sticky watchdog flag
- `busy`  out  1  state is ARB_ACCESS

## Operation
- Per port: pending bit + holding register (addr, wdata, wmask, we). Request pulse sets pending and captures fields.
- Request while that port is already pending: ignored (fields unchanged).
- `d_read` and `d_write` together: treated as write.
- FSM ARB_IDLE: if any pending, pick port; both pending → port opposite `last_grant`; go ARB_ACCESS, drive registered mem bus from chosen holding register, update `last_grant`.
- ARB_ACCESS: strobe held, bus stable, counter increments each cycle. On `mem_resp`=1: drop strobes, capture `mem_rdata` (reads only) into port rdata, pulse port resp, clear pending, go ARB_IDLE.
- Counter reaches `TIMEOUT` without `mem_resp`: drop strobes, pulse port resp, rdata = `ARB_TIMEOUT_RDATA` (32'hDEAD_BEEF) for reads, set `timeout_err`, go ARB_IDLE.
- `mem_resp` in ARB_IDLE: ignored.
- New request on a port in the same edge its pending clears: set wins, new request buffered.
- Counter width $clog2(TIMEOUT+1); cleared on entry to ARB_ACCESS.

## Timing
- Reset values: all strobes, resp, `busy`, `timeout_err` 0; addr/wdata/wmask/rdata 0; pending 0; `last_grant`=GNT_D (fetch wins first tie); state ARB_IDLE.
- `rst` asserted mid-access: all outputs to reset values immediately (asynchronous), buffered requests lost.
- Request pulse in cycle 0, idle arbiter: pending set at edge 0; grant at edge 1; strobe high from cycle 2.
- `mem_resp` sampled high in cycle k: strobe low and resp high in cycle k+1; resp low in k+2; arbiter may strobe again from cycle k+2 if other port pending.
- Minimum request-to-resp latency with `mem_resp` in first strobe cycle: 3 cycles.
- Timeout: strobe high for exactly `TIMEOUT` cycles, resp in the next cycle.

## Structure
- Shared package: `arb_state_t` {ARB_IDLE, ARB_ACCESS}, `arb_grant_t` {GNT_I, GNT_D}, `ARB_TIMEOUT_RDATA`.
- Sub-module `arb_port_buffer` (pending bit + holding register, set/clear logic) instantiated twice; top holds FSM, round-robin, counter, output registers.

## Test plan
- Single fetch `i_addr`=0x100, memory answers after 2 strobe cycles with 0x00000013 → `mem_read` high 2 cycles, `i_resp` one pulse, `i_rdata`=0x00000013 held.
- `i_req` and `d_read` same cycle from reset → fetch served first, then data; next simultaneous pair → data first.
- Store `d_addr`=0x200, `d_wdata`=0xCAFEF00D, mask 4'b0011 → `mem_write` with exact bus values, `d_resp` pulse, `d_rdata` unchanged.
- `TIMEOUT`=4, `mem_resp` never → strobe 4 cycles, resp pulse, rdata 0xDEADBEEF, `timeout_err`=1 until reset.
- `rst` pulsed mid-access with both ports pending → strobes drop same cycle, nothing issued afterward until new request.
- Second `i_req` (addr 0x300) while first pending → ignored; only 0x100 reaches `mem_addr`.
